// File: rtl/vram_pixel_serializer.sv
// vram_pixel_serializer: captures 16-bit bitmap words from video RAM and
// serialises them into one 4-bit pixel per ce_pix, with blank delay.
//
// Ports:
//   clk, reset   sole clock; asynchronous active-high reset
//   ce_pix       pixel-rate clock enable; all state qualifies on it
//   LOAD_SLOT    DRAM_D holds the word fetched at the scan address
//   DRAM_D       16-bit bitmap word (4 pixels x 4 bpp)
//   LINE_START   one-ce pulse at the first pixel phase of a scanline
//   FINE         phase at which the held word moves to the shifter
//   FLIP         0: nibble [15:12] first, 1: nibble [3:0] first
//   BLANK        undelayed combined H/V blank
//   PIX          serialised pixel, forced to 0 while BLANK_OUT=1
//   BLANK_OUT    BLANK delayed by BLANK_DLY ce_pix cycles
//   UNDERRUN     sticky flag: a transfer found no fresh word held
module vram_pixel_serializer #(
  parameter int BLANK_DLY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        LOAD_SLOT,
  input  logic [15:0] DRAM_D,
  input  logic        LINE_START,
  input  logic [1:0]  FINE,
  input  logic        FLIP,
  input  logic        BLANK,
  output logic [3:0]  PIX,
  output logic        BLANK_OUT,
  output logic        UNDERRUN
);

  logic [1:0]           pcnt;
  logic [1:0]           eff;
  logic                 xfer;
  logic [15:0]          holding;
  logic [15:0]          shifter;
  logic [15:0]          shifter_nx;
  logic                 valid;
  logic [3:0]           pix_q;
  logic [3:0]           pix_nx;
  logic [BLANK_DLY-1:0] blk;

  // LINE_START realigns the phase to 0 on the very cycle it is seen.
  always_comb begin
    eff  = LINE_START ? 2'd0 : pcnt;
    xfer = (eff == FINE);
  end

  // A transfer reads the old holding word even when a load lands
  // in the same cycle; the new word waits in holding.
  always_comb begin
    pix_nx     = 4'h0;
    shifter_nx = 16'h0;
    unique case (1'b1)
      xfer && !FLIP: begin
        pix_nx     = holding[15:12];
        shifter_nx = {holding[11:0], 4'h0};
      end
      xfer && FLIP: begin
        pix_nx     = holding[3:0];
        shifter_nx = {4'h0, holding[15:4]};
      end
      !xfer && !FLIP: begin
        pix_nx     = shifter[15:12];
        shifter_nx = {shifter[11:0], 4'h0};
      end
      default: begin
        pix_nx     = shifter[3:0];
        shifter_nx = {4'h0, shifter[15:4]};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt     <= 2'd0;
      holding  <= 16'h0;
      shifter  <= 16'h0;
      valid    <= 1'b0;
      pix_q    <= 4'h0;
      UNDERRUN <= 1'b0;
    end else if (ce_pix) begin
      pcnt    <= eff + 2'd1;
      pix_q   <= pix_nx;
      shifter <= shifter_nx;
      if (LOAD_SLOT) begin
        holding <= DRAM_D;
      end
      if (LOAD_SLOT) begin
        valid <= 1'b1;
      end else if (xfer) begin
        valid <= 1'b0;
      end
      if (xfer && !valid) begin
        UNDERRUN <= 1'b1;
      end
    end
  end

  // Blank delay line; starts full so the screen is blank after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk <= '1;
    end else if (ce_pix) begin
      blk[0] <= BLANK;
      for (int i = 1; i < BLANK_DLY; i++) begin
        blk[i] <= blk[i-1];
      end
    end
  end

  assign BLANK_OUT = blk[BLANK_DLY-1];
  assign PIX       = BLANK_OUT ? 4'h0 : pix_q;

endmodule
